// File: rtl/button_step_gen.sv
// Purpose: synchronize and debounce Up/Down buttons, emit one-cycle inc/dec steps with hold-to-repeat.
// Latency: raw edge to first step pulse is 3+DEBOUNCE_CYCLES cycles; repeats follow REPEAT_DELAY then REPEAT_PERIOD.
// Backpressure: none; pulses are fire-and-forget, and en=0 parks the step FSM in LOCK.
module button_step_gen #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 50000000,
  parameter int REPEAT_PERIOD   = 10000000,
  parameter int CNT_W           = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic btnU,
  input  logic btnD,
  input  logic en,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic btnU_level,
  output logic btnD_level
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST  = CNT_W'(REPEAT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = '0;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HOLD_U = 3'd1,
    RPT_U  = 3'd2,
    HOLD_D = 3'd3,
    RPT_D  = 3'd4,
    LOCK   = 3'd5
  } state_t;

  logic [1:0]       sync_u;
  logic [1:0]       sync_d;
  logic             s_u;
  logic             s_d;
  logic [CNT_W-1:0] cnt_u;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W-1:0] timer;
  logic [CNT_W-1:0] timer_n;
  state_t           state;
  state_t           state_n;
  logic             inc_n;
  logic             dec_n;

  assign s_u = sync_u[1];
  assign s_d = sync_d[1];

  // Two-flop synchronizers bring the raw buttons into the clk domain.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_u <= 2'b00;
      sync_d <= 2'b00;
    end else begin
      sync_u <= {sync_u[0], btnU};
      sync_d <= {sync_d[0], btnD};
    end
  end

  // Debouncers: the level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_u      <= CNT_ZERO;
      cnt_d      <= CNT_ZERO;
      btnU_level <= 1'b0;
      btnD_level <= 1'b0;
    end else begin
      if (s_u == btnU_level) begin
        cnt_u <= CNT_ZERO;
      end else if (cnt_u == DB_LAST) begin
        btnU_level <= s_u;
        cnt_u      <= CNT_ZERO;
      end else begin
        cnt_u <= cnt_u + CNT_ONE;
      end
      if (s_d == btnD_level) begin
        cnt_d <= CNT_ZERO;
      end else if (cnt_d == DB_LAST) begin
        btnD_level <= s_d;
        cnt_d      <= CNT_ZERO;
      end else begin
        cnt_d <= cnt_d + CNT_ONE;
      end
    end
  end

  // Step FSM next-state: first press pulses at once, holding repeats; both buttons or en=0 lock out.
  always_comb begin
    state_n = state;
    timer_n = timer;
    inc_n   = 1'b0;
    dec_n   = 1'b0;
    if (!en) begin
      state_n = LOCK;
      timer_n = CNT_ZERO;
    end else begin
      case (state)
        IDLE: begin
          timer_n = CNT_ZERO;
          if (btnU_level && btnD_level) begin
            state_n = LOCK;
          end else if (btnU_level) begin
            state_n = HOLD_U;
            inc_n   = 1'b1;
          end else if (btnD_level) begin
            state_n = HOLD_D;
            dec_n   = 1'b1;
          end
        end
        HOLD_U, RPT_U: begin
          if (!btnU_level) begin
            state_n = IDLE;
            timer_n = CNT_ZERO;
          end else if (btnD_level) begin
            state_n = LOCK;
            timer_n = CNT_ZERO;
          end else if (timer == ((state == HOLD_U) ? RD_LAST : RP_LAST)) begin
            state_n = RPT_U;
            timer_n = CNT_ZERO;
            inc_n   = 1'b1;
          end else begin
            timer_n = timer + CNT_ONE;
          end
        end
        HOLD_D, RPT_D: begin
          if (!btnD_level) begin
            state_n = IDLE;
            timer_n = CNT_ZERO;
          end else if (btnU_level) begin
            state_n = LOCK;
            timer_n = CNT_ZERO;
          end else if (timer == ((state == HOLD_D) ? RD_LAST : RP_LAST)) begin
            state_n = RPT_D;
            timer_n = CNT_ZERO;
            dec_n   = 1'b1;
          end else begin
            timer_n = timer + CNT_ONE;
          end
        end
        LOCK: begin
          timer_n = CNT_ZERO;
          if (!btnU_level && !btnD_level) begin
            state_n = IDLE;
          end
        end
        default: begin
          state_n = IDLE;
          timer_n = CNT_ZERO;
        end
      endcase
    end
  end

  // State, shared timer and registered one-cycle step pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      timer     <= CNT_ZERO;
      inc_pulse <= 1'b0;
      dec_pulse <= 1'b0;
    end else begin
      state     <= state_n;
      timer     <= timer_n;
      inc_pulse <= inc_n;
      dec_pulse <= dec_n;
    end
  end

endmodule

// File: tb/tb_button_step_gen.sv
// Purpose: directed self-checking bench for button_step_gen with small timing parameters.
// Latency: expected pulse cycles are hand-computed offsets from each press.
// Backpressure: not applicable; pulses are logged every cycle and compared afterwards.
module tb_button_step_gen;

  logic clk;
  logic rst;
  logic btnU;
  logic btnD;
  logic en;
  logic inc_pulse;
  logic dec_pulse;
  logic btnU_level;
  logic btnD_level;

  int cyc;
  int tests;
  int fails;
  int both_cnt;
  int inc_q[$];
  int dec_q[$];

  button_step_gen #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (20),
    .REPEAT_PERIOD  (8),
    .CNT_W          (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btnU      (btnU),
    .btnD      (btnD),
    .en        (en),
    .inc_pulse (inc_pulse),
    .dec_pulse (dec_pulse),
    .btnU_level(btnU_level),
    .btnD_level(btnD_level)
  );

  always #5 clk = ~clk;

  // Cycle N is the interval following the N-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Log pulse cycles and any overlap of the two pulses.
  always @(negedge clk) begin
    if (inc_pulse) inc_q.push_back(cyc);
    if (dec_pulse) dec_q.push_back(cyc);
    if (inc_pulse && dec_pulse) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic check_pulses(input string tag, input bit is_dec, input int t0,
                              input int e[8], input int n);
    int sz;
    int got;
    sz = is_dec ? dec_q.size() : inc_q.size();
    check({tag, "_count"}, sz, n);
    for (int i = 0; i < n; i++) begin
      if (i < sz) got = (is_dec ? dec_q[i] : inc_q[i]) - t0;
      else got = -1;
      check($sformatf("%s_%0d", tag, i), got, e[i]);
    end
  endtask

  task automatic clear_logs();
    inc_q.delete();
    dec_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    clk = 1'b0; rst = 1'b1; btnU = 1'b0; btnD = 1'b0; en = 1'b1;
    cyc = 0; tests = 0; fails = 0; both_cnt = 0;

    // Reset state
    wait_to(3);
    check("rst_inc", inc_pulse, 0);
    check("rst_dec", dec_pulse, 0);
    check("rst_lvlU", btnU_level, 0);
    check("rst_lvlD", btnD_level, 0);
    rst = 1'b0;
    wait_to(5);
    clear_logs();

    // 1: short press, one pulse at +7, level high at +6, low 6 after release
    t0 = 10;
    wait_to(t0); btnU = 1'b1;
    wait_to(t0 + 5); check("t1_lvl_pre", btnU_level, 0); btnU = 1'b0;
    wait_to(t0 + 6); check("t1_lvl_up", btnU_level, 1);
    wait_to(t0 + 10); check("t1_lvl_hold", btnU_level, 1);
    wait_to(t0 + 11); check("t1_lvl_down", btnU_level, 0);
    wait_to(t0 + 30);
    check_pulses("t1_inc", 0, t0, '{7, 0, 0, 0, 0, 0, 0, 0}, 1);
    check_pulses("t1_dec", 1, t0, '{default: 0}, 0);
    clear_logs();

    // 2: hold with auto-repeat, release stops pulses
    t0 = 50;
    wait_to(t0); btnU = 1'b1;
    wait_to(t0 + 56); btnU = 1'b0;
    wait_to(t0 + 61); check("t2_lvl_hold", btnU_level, 1);
    wait_to(t0 + 62); check("t2_lvl_down", btnU_level, 0);
    wait_to(t0 + 90);
    check_pulses("t2_inc", 0, t0, '{7, 27, 35, 43, 51, 59, 0, 0}, 6);
    clear_logs();

    // 3: bouncing Down button, then stable high
    t0 = 150;
    for (int k = 0; k < 30; k++) begin
      wait_to(t0 + k);
      btnD = (((k / 2) % 2) == 0);
    end
    wait_to(t0 + 50); btnD = 1'b0;
    check_pulses("t3_dec", 1, t0, '{35, 0, 0, 0, 0, 0, 0, 0}, 1);
    check_pulses("t3_inc", 0, t0, '{default: 0}, 0);
    wait_to(t0 + 70);
    clear_logs();

    // 4: second button locks out; only a fresh press after full release steps
    t0 = 230;
    wait_to(t0); btnU = 1'b1;
    wait_to(t0 + 30); btnD = 1'b1;
    wait_to(t0 + 50); btnU = 1'b0;
    wait_to(t0 + 90); btnD = 1'b0;
    wait_to(t0 + 110); btnD = 1'b1;
    wait_to(t0 + 120); btnD = 1'b0;
    wait_to(t0 + 140);
    check_pulses("t4_inc", 0, t0, '{7, 27, 35, 0, 0, 0, 0, 0}, 3);
    check_pulses("t4_dec", 1, t0, '{117, 0, 0, 0, 0, 0, 0, 0}, 1);
    clear_logs();

    // 5: en low during press, raised while held, then re-press
    t0 = 380;
    wait_to(t0); en = 1'b0; btnU = 1'b1;
    wait_to(t0 + 20); en = 1'b1;
    wait_to(t0 + 60); btnU = 1'b0;
    wait_to(t0 + 70); btnU = 1'b1;
    wait_to(t0 + 90); btnU = 1'b0;
    wait_to(t0 + 110);
    check_pulses("t5_inc", 0, t0, '{77, 0, 0, 0, 0, 0, 0, 0}, 1);
    clear_logs();

    // 6: one-cycle reset mid-repeat, button still held
    t0 = 500;
    wait_to(t0); btnU = 1'b1;
    wait_to(t0 + 38); rst = 1'b1;
    wait_to(t0 + 39); rst = 1'b0;
    check("t6_inc_rst", inc_pulse, 0);
    check("t6_dec_rst", dec_pulse, 0);
    check("t6_lvlU_rst", btnU_level, 0);
    wait_to(t0 + 55); btnU = 1'b0;
    wait_to(t0 + 80);
    check_pulses("t6_inc", 0, t0, '{7, 27, 35, 46, 0, 0, 0, 0}, 4);
    check_pulses("t6_dec", 1, t0, '{default: 0}, 0);

    check("no_overlap", both_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/button_step_gen.md
Name: button_step_gen

Overview:
Conditions the raw up/down push-buttons for the digital clock's digit-edit stage. Each input passes through a synchronizer and a debouncer. The block then emits single-cycle increment/decrement step pulses, with hold-to-auto-repeat. The downstream counter/display block consumes inc_pulse/dec_pulse directly in place of its own debounce logic.

Parameters:
DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before the debounced level changes (min 1)
REPEAT_DELAY, 50000000, cycles from the first pulse to the first auto-repeat pulse while held (min 1)
REPEAT_PERIOD, 10000000, cycles between auto-repeat pulses after the first repeat (min 1)
CNT_W, 32, width of the debounce and repeat timers; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
btnU  input  1  raw Up button, asynchronous, active-high
btnD  input  1  raw Down button, asynchronous, active-high
en  input  1  step-generation enable (edit mode active)
inc_pulse  output  1  one-cycle increment step
dec_pulse  output  1  one-cycle decrement step
btnU_level  output  1  debounced Up level
btnD_level  output  1  debounced Down level

Behaviour:
- One clock domain. Reset is synchronous, active-high, sampled on posedge clk.
- Reset values: all outputs 0, both synchronizer flops 0, both timers 0, FSM in IDLE.
- Synchronizer: 2-flop per button. The synchronized value sU/sD lags the raw input by 2 cycles.
- Debouncer (per button):
  - cnt increments each cycle that s != level.
  - Any cycle with s == level clears cnt to 0.
  - When s != level and cnt == DEBOUNCE_CYCLES-1: level <= s, cnt <= 0.
  - Result: level follows s exactly DEBOUNCE_CYCLES cycles after s settles. Glitches shorter than DEBOUNCE_CYCLES are ignored. Release is debounced identically.
- Step FSM states: IDLE, HOLD_U, RPT_U, HOLD_D, RPT_D, LOCK. A single shared timer is used, width CNT_W.
- IDLE:
  - levelU & levelD -> LOCK.
  - levelU only -> HOLD_U, timer=0, inc_pulse=1 next cycle.
  - levelD only -> HOLD_D, timer=0, dec_pulse=1 next cycle.
- HOLD_x:
  - If level_x falls -> IDLE.
  - Else if the other level rises -> LOCK.
  - Else if timer == REPEAT_DELAY-1 -> RPT_x, timer=0, pulse.
  - Else timer++.
- RPT_x: same as HOLD_x, using REPEAT_PERIOD and staying in RPT_x on expiry.
- LOCK: no pulses; -> IDLE only when levelU=0 and levelD=0.
- en=0: the FSM is forced to LOCK every cycle and no pulses are issued. A button held across en rising produces no pulse until it is released and pressed again. This takes priority over all other transitions.
- Pulses are registered and high for exactly 1 cycle. inc_pulse and dec_pulse are never high in the same cycle.
- Latency: if level first reads 1 at cycle L, the first pulse is at L+1. Raw edge to pulse totals 3+DEBOUNCE_CYCLES cycles.
- Repeat pulses while held: L+1, L+1+REPEAT_DELAY, then every REPEAT_PERIOD thereafter.
- Timers saturate logically: they are always cleared on a state change, so there is no wrap within a state.

Test Plan:
1. Params DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, en=1. Raise btnU at cycle 10 and hold 5 cycles -> btnU_level=1 at cycle 16, exactly one inc_pulse at cycle 17, no dec_pulse.
2. btnU held continuously from cycle 10 -> inc_pulse at 17, 37, 45, 53, …; btnU released -> pulses stop, and btnU_level falls 6 cycles after the release edge.
3. btnD toggling every 2 cycles for 30 cycles (bounce), then stable high -> no pulse during the bounce; a single dec_pulse 7 cycles after the final rising edge.
4. btnU held and pulsing, then btnD pressed -> enter LOCK with no further pulses. Release btnU only -> still none. Release both, then press btnD -> one dec_pulse.
5. en=0 while btnU is pressed, then en=1 while still held -> no pulse. Release and re-press -> inc_pulse.
6. rst asserted for 1 cycle mid-repeat -> all outputs 0 the next cycle. With btnU still high, inc_pulse is next seen 3+DEBOUNCE_CYCLES cycles after rst deasserts.
